fifo_wr_arb: RTL

- Round-robin write-side arbiter that shares one synchronous FIFO write port among N requesters.
- Supports multi-beat bursts: once a requester wins, it holds the port until its last beat or until a burst-length cap forces release.
- Sits directly in front of the FIFO write port (wvalid/wready/wdata).
- Provides grant visibility and a forced-release pulse for debug and counters.

---
 rtl/fifo_wr_arb.sv | 119 +++++++++++
 1 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter: N requesters share one FIFO write port,
// with burst locking and a MaxBurst cap that forces release.
module fifo_wr_arb #(
    parameter int N        = 4,
    parameter int Width    = 16,
    parameter int MaxBurst = 4,
    parameter int IdxW     = $clog2(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic [N-1:0]         req_valid_i,
    input  logic [N-1:0]         req_last_i,
    input  logic [N*Width-1:0]   req_data_i,
    output logic [N-1:0]         req_ready_o,
    output logic                 fifo_wvalid_o,
    input  logic                 fifo_wready_i,
    output logic [Width-1:0]     fifo_wdata_o,
    output logic [IdxW-1:0]      gnt_idx_o,
    output logic                 locked_o,
    output logic                 trunc_o
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;

    logic              kill;
    logic [IdxW-1:0]   idle_sel, cand, sel;
    logic              found;
    logic              wvalid, beat, sel_last, cap_hit, release_w;
    logic [7:0]        cnt_inc;
    logic [Width-1:0]  data_arr [N];

    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] v);
        if ({1'b0, v} == (IdxW+1)'(N-1)) return '0;
        return v + IdxW'(1);
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_data
        assign data_arr[k] = req_data_i[k*Width +: Width];
    end

    // Scan from rr_ptr upward, wrapping modulo N; the first valid requester wins.
    always_comb begin
        idle_sel = rr_ptr_q;
        found    = 1'b0;
        cand     = rr_ptr_q;
        for (int i = 0; i < N; i++) begin
            if (!found && req_valid_i[cand]) begin
                idle_sel = cand;
                found    = 1'b1;
            end
            cand = wrap_inc(cand);
        end
    end

    assign sel       = (state_q == LOCKED) ? owner_q : idle_sel;
    assign kill      = rst_i | clr_i;
    assign wvalid    = req_valid_i[sel] & ~kill;
    assign beat      = wvalid & fifo_wready_i;
    assign sel_last  = req_last_i[sel];
    assign cnt_inc   = beat_cnt_q + 8'd1;
    assign cap_hit   = (state_q == LOCKED) ? (cnt_inc == 8'(MaxBurst)) : (MaxBurst == 1);
    assign release_w = beat & (sel_last | cap_hit);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (beat) begin
            if (release_w) begin
                // Releasing requester drops to lowest priority.
                state_d    = IDLE;
                rr_ptr_d   = wrap_inc(sel);
                beat_cnt_d = '0;
            end else begin
                state_d    = LOCKED;
                owner_d    = sel;
                beat_cnt_d = cnt_inc;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_ready_o[k] = (sel == IdxW'(k)) & fifo_wready_i & ~kill;
        end
        fifo_wvalid_o = wvalid;
        fifo_wdata_o  = wvalid ? data_arr[sel] : '0;
        gnt_idx_o     = sel;
        locked_o      = (state_q == LOCKED);
        trunc_o       = release_w & ~sel_last;
    end

    a_ready_onehot0: assert property (@(posedge clk_i) $onehot0(req_ready_o));
    a_wvalid_req:    assert property (@(posedge clk_i) fifo_wvalid_o |-> req_valid_i[gnt_idx_o]);
    a_beat_cnt:      assert property (@(posedge clk_i) disable iff (rst_i) beat_cnt_q < 8'(MaxBurst));
    a_gnt_range:     assert property (@(posedge clk_i) disable iff (rst_i) {1'b0, gnt_idx_o} < (IdxW+1)'(N));

endmodule
